// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: dual dispatch, triple completion,
// in-order dual retirement with registered retire outputs.
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4,
    parameter int PREG_W = 6,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_a_valid,
    input  logic [PTR_W-1:0]  disp_a_robnum,
    input  logic [PC_W-1:0]   disp_a_pc,
    input  logic [PREG_W-1:0] disp_a_rd,
    input  logic [PREG_W-1:0] disp_a_rd_old,
    input  logic              disp_a_regwrite,
    input  logic              disp_a_memwrite,
    input  logic              disp_b_valid,
    input  logic [PTR_W-1:0]  disp_b_robnum,
    input  logic [PC_W-1:0]   disp_b_pc,
    input  logic [PREG_W-1:0] disp_b_rd,
    input  logic [PREG_W-1:0] disp_b_rd_old,
    input  logic              disp_b_regwrite,
    input  logic              disp_b_memwrite,
    input  logic              cmp_a_valid,
    input  logic [PTR_W-1:0]  cmp_a_robnum,
    input  logic              cmp_b_valid,
    input  logic [PTR_W-1:0]  cmp_b_robnum,
    input  logic              cmp_c_valid,
    input  logic [PTR_W-1:0]  cmp_c_robnum,
    output logic              ret_a_valid,
    output logic              ret_b_valid,
    output logic [PC_W-1:0]   ret_a_pc,
    output logic [PC_W-1:0]   ret_b_pc,
    output logic [PREG_W-1:0] ret_a_rd,
    output logic [PREG_W-1:0] ret_b_rd,
    output logic [PREG_W-1:0] ret_a_free,
    output logic [PREG_W-1:0] ret_b_free,
    output logic              ret_a_free_valid,
    output logic              ret_b_free_valid,
    output logic              ret_a_store,
    output logic              ret_b_store,
    output logic [PTR_W:0]    occupancy,
    output logic              rob_full,
    output logic              rob_empty,
    output logic              err
);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [DEPTH-1:0]  rw_q, mw_q;
    logic [PC_W-1:0]   pc_q  [DEPTH];
    logic [PREG_W-1:0] rd_q  [DEPTH];
    logic [PREG_W-1:0] rdo_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   occ_q, occ_d;
    logic             err_q, err_d;

    logic [PTR_W-1:0] head_p1, tail_p1, b_idx;
    logic [1:0]       disp_cnt, acc_cnt, ret_cnt;
    logic [PTR_W+1:0] occ_sum;
    logic             rn_ok, cap_ok, disp_ok, disp_err;
    logic             acc_a, acc_b, ret_a, ret_b;
    logic [DEPTH-1:0] wr_mask, ret_mask, cmp_mask;
    logic             cmp_err;
    logic [2:0]       cv;
    logic [PTR_W-1:0] cr [3];

    assign head_p1 = head_q + 1'b1;
    assign tail_p1 = tail_q + 1'b1;
    assign b_idx   = disp_a_valid ? tail_p1 : tail_q;

    assign disp_cnt = {1'b0, disp_a_valid} + {1'b0, disp_b_valid};
    assign occ_sum  = {1'b0, occ_q} + (PTR_W+2)'(disp_cnt);
    assign cap_ok   = occ_sum <= (PTR_W+2)'(DEPTH);
    assign rn_ok    = (!disp_a_valid || disp_a_robnum == tail_q) &&
                      (!disp_b_valid || disp_b_robnum == b_idx);
    assign disp_ok  = rn_ok && cap_ok;
    assign disp_err = (disp_cnt != 2'd0) && !disp_ok;
    assign acc_a    = disp_a_valid && disp_ok;
    assign acc_b    = disp_b_valid && disp_ok;
    assign acc_cnt  = {1'b0, acc_a} + {1'b0, acc_b};

    // Retirement looks only at registered valid/done state.
    assign ret_a   = valid_q[head_q] && done_q[head_q];
    assign ret_b   = ret_a && valid_q[head_p1] && done_q[head_p1];
    assign ret_cnt = {1'b0, ret_a} + {1'b0, ret_b};

    assign cv    = {cmp_c_valid, cmp_b_valid, cmp_a_valid};
    assign cr[0] = cmp_a_robnum;
    assign cr[1] = cmp_b_robnum;
    assign cr[2] = cmp_c_robnum;

    always_comb begin
        wr_mask  = '0;
        ret_mask = '0;
        if (acc_a) wr_mask[tail_q] = 1'b1;
        if (acc_b) wr_mask[b_idx]  = 1'b1;
        if (ret_a) ret_mask[head_q]  = 1'b1;
        if (ret_b) ret_mask[head_p1] = 1'b1;
    end

    always_comb begin
        cmp_mask = '0;
        cmp_err  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (cv[k]) begin
                if (valid_q[cr[k]] && !wr_mask[cr[k]])
                    cmp_mask[cr[k]] = 1'b1;
                else
                    cmp_err = 1'b1;
            end
        end
    end

    always_comb begin
        valid_d = (valid_q | wr_mask) & ~ret_mask;
        done_d  = (done_q | cmp_mask) & ~wr_mask & ~ret_mask;
        head_d  = head_q + PTR_W'(ret_cnt);
        tail_d  = tail_q + PTR_W'(acc_cnt);
        occ_d   = occ_q + (PTR_W+1)'(acc_cnt) - (PTR_W+1)'(ret_cnt);
        err_d   = err_q || disp_err || cmp_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q          <= '0;
            done_q           <= '0;
            head_q           <= '0;
            tail_q           <= '0;
            occ_q            <= '0;
            err_q            <= 1'b0;
            ret_a_valid      <= 1'b0;
            ret_b_valid      <= 1'b0;
            ret_a_pc         <= '0;
            ret_b_pc         <= '0;
            ret_a_rd         <= '0;
            ret_b_rd         <= '0;
            ret_a_free       <= '0;
            ret_b_free       <= '0;
            ret_a_free_valid <= 1'b0;
            ret_b_free_valid <= 1'b0;
            ret_a_store      <= 1'b0;
            ret_b_store      <= 1'b0;
        end else begin
            valid_q          <= valid_d;
            done_q           <= done_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            occ_q            <= occ_d;
            err_q            <= err_d;
            ret_a_valid      <= ret_a;
            ret_b_valid      <= ret_b;
            ret_a_pc         <= ret_a ? pc_q[head_q]  : '0;
            ret_b_pc         <= ret_b ? pc_q[head_p1] : '0;
            ret_a_rd         <= ret_a ? rd_q[head_q]  : '0;
            ret_b_rd         <= ret_b ? rd_q[head_p1] : '0;
            ret_a_free       <= ret_a ? rdo_q[head_q]  : '0;
            ret_b_free       <= ret_b ? rdo_q[head_p1] : '0;
            ret_a_free_valid <= ret_a && rw_q[head_q] &&
                                (rdo_q[head_q] != '0);
            ret_b_free_valid <= ret_b && rw_q[head_p1] &&
                                (rdo_q[head_p1] != '0);
            ret_a_store      <= ret_a && mw_q[head_q];
            ret_b_store      <= ret_b && mw_q[head_p1];
        end
    end

    // Payload needs no reset: it is only observed through valid entries.
    always_ff @(posedge clk) begin
        if (!reset && acc_a) begin
            pc_q[tail_q]  <= disp_a_pc;
            rd_q[tail_q]  <= disp_a_rd;
            rdo_q[tail_q] <= disp_a_rd_old;
            rw_q[tail_q]  <= disp_a_regwrite;
            mw_q[tail_q]  <= disp_a_memwrite;
        end
        if (!reset && acc_b) begin
            pc_q[b_idx]  <= disp_b_pc;
            rd_q[b_idx]  <= disp_b_rd;
            rdo_q[b_idx] <= disp_b_rd_old;
            rw_q[b_idx]  <= disp_b_regwrite;
            mw_q[b_idx]  <= disp_b_memwrite;
        end
    end

    assign occupancy = occ_q;
    assign rob_full  = occ_q > (PTR_W+1)'(DEPTH - 2);
    assign rob_empty = occ_q == '0;
    assign err       = err_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed steps plus random traffic,
// checked against a program-order queue model.
module tb_reorder_buffer;

    logic        clk;
    logic        reset;
    logic        a_v, b_v;
    logic [3:0]  a_rn, b_rn;
    logic [31:0] a_pc, b_pc;
    logic [5:0]  a_rd, b_rd, a_rdo, b_rdo;
    logic        a_rw, b_rw, a_mw, b_mw;
    logic        c_v [3];
    logic [3:0]  c_rn [3];

    logic        ra_v, rb_v;
    logic [31:0] ra_pc, rb_pc;
    logic [5:0]  ra_rd, rb_rd, ra_fr, rb_fr;
    logic        ra_fv, rb_fv, ra_st, rb_st;
    logic [4:0]  occ;
    logic        full, empty, err;

    reorder_buffer dut (
        .clk(clk), .reset(reset),
        .disp_a_valid(a_v), .disp_a_robnum(a_rn), .disp_a_pc(a_pc),
        .disp_a_rd(a_rd), .disp_a_rd_old(a_rdo),
        .disp_a_regwrite(a_rw), .disp_a_memwrite(a_mw),
        .disp_b_valid(b_v), .disp_b_robnum(b_rn), .disp_b_pc(b_pc),
        .disp_b_rd(b_rd), .disp_b_rd_old(b_rdo),
        .disp_b_regwrite(b_rw), .disp_b_memwrite(b_mw),
        .cmp_a_valid(c_v[0]), .cmp_a_robnum(c_rn[0]),
        .cmp_b_valid(c_v[1]), .cmp_b_robnum(c_rn[1]),
        .cmp_c_valid(c_v[2]), .cmp_c_robnum(c_rn[2]),
        .ret_a_valid(ra_v), .ret_b_valid(rb_v),
        .ret_a_pc(ra_pc), .ret_b_pc(rb_pc),
        .ret_a_rd(ra_rd), .ret_b_rd(rb_rd),
        .ret_a_free(ra_fr), .ret_b_free(rb_fr),
        .ret_a_free_valid(ra_fv), .ret_b_free_valid(rb_fv),
        .ret_a_store(ra_st), .ret_b_store(rb_st),
        .occupancy(occ), .rob_full(full), .rob_empty(empty), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [3:0]  rn;
        logic [31:0] pc;
        logic [5:0]  rd;
        logic [5:0]  rdo;
        bit          rw;
        bit          mw;
        bit          done;
    } ent_t;

    ent_t        q[$];
    int          m_tail;
    bit          m_err;
    int          errors;
    int          checks;
    logic [31:0] seen[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        a_v = 0; a_rn = 0; a_pc = 0; a_rd = 0; a_rdo = 0; a_rw = 0; a_mw = 0;
        b_v = 0; b_rn = 0; b_pc = 0; b_rd = 0; b_rdo = 0; b_rw = 0; b_mw = 0;
        for (int k = 0; k < 3; k++) begin
            c_v[k] = 0;
            c_rn[k] = 0;
        end
    endtask

    task automatic dA(input logic [3:0] rn, input logic [31:0] pc,
                      input logic [5:0] rd, input logic [5:0] rdo,
                      input bit rw, input bit mw);
        a_v = 1; a_rn = rn; a_pc = pc; a_rd = rd; a_rdo = rdo;
        a_rw = rw; a_mw = mw;
    endtask

    task automatic dB(input logic [3:0] rn, input logic [31:0] pc,
                      input logic [5:0] rd, input logic [5:0] rdo,
                      input bit rw, input bit mw);
        b_v = 1; b_rn = rn; b_pc = pc; b_rd = rd; b_rdo = rdo;
        b_rw = rw; b_mw = mw;
    endtask

    task automatic cmp(input int k, input logic [3:0] rn);
        c_v[k] = 1;
        c_rn[k] = rn;
    endtask

    // Predict the edge from the model, advance the clock, compare.
    task automatic step();
        ent_t ea, eb;
        bit   va, vb, ok, found;
        int   cnt, occ0;
        logic [3:0] bexp;
        va = 0; vb = 0;
        ea = '{default: 0};
        eb = '{default: 0};
        if (reset) begin
            q.delete();
            m_tail = 0;
            m_err = 0;
        end else begin
            occ0 = q.size();
            va = occ0 > 0 && q[0].done;
            vb = va && occ0 > 1 && q[1].done;
            if (va) ea = q[0];
            if (vb) eb = q[1];
            for (int k = 0; k < 3; k++) begin
                if (c_v[k]) begin
                    found = 0;
                    foreach (q[i]) if (q[i].rn == c_rn[k]) begin
                        q[i].done = 1;
                        found = 1;
                    end
                    if (!found) m_err = 1;
                end
            end
            cnt = int'(a_v) + int'(b_v);
            bexp = a_v ? 4'(m_tail + 1) : 4'(m_tail);
            ok = (occ0 + cnt <= 16);
            if (a_v && a_rn != 4'(m_tail)) ok = 0;
            if (b_v && b_rn != bexp) ok = 0;
            if (vb) q.pop_front();
            if (va) q.pop_front();
            if (cnt > 0 && !ok) m_err = 1;
            if (cnt > 0 && ok) begin
                if (a_v) q.push_back('{a_rn, a_pc, a_rd, a_rdo, a_rw, a_mw, 0});
                if (b_v) q.push_back('{b_rn, b_pc, b_rd, b_rdo, b_rw, b_mw, 0});
                m_tail = (m_tail + cnt) % 16;
            end
        end
        @(posedge clk);
        #1;
        if (ra_v) seen.push_back(ra_pc);
        if (rb_v) seen.push_back(rb_pc);
        chk("ret_a_valid", ra_v, va);
        chk("ret_b_valid", rb_v, vb);
        chk("ret_a_pc", ra_pc, va ? ea.pc : 0);
        chk("ret_b_pc", rb_pc, vb ? eb.pc : 0);
        chk("ret_a_rd", ra_rd, va ? ea.rd : 0);
        chk("ret_b_rd", rb_rd, vb ? eb.rd : 0);
        chk("ret_a_free", ra_fr, va ? ea.rdo : 0);
        chk("ret_b_free", rb_fr, vb ? eb.rdo : 0);
        chk("ret_a_free_valid", ra_fv, va && ea.rw && ea.rdo != 0);
        chk("ret_b_free_valid", rb_fv, vb && eb.rw && eb.rdo != 0);
        chk("ret_a_store", ra_st, va && ea.mw);
        chk("ret_b_store", rb_st, vb && eb.mw);
        chk("occupancy", occ, q.size());
        chk("rob_full", full, q.size() > 14);
        chk("rob_empty", empty, q.size() == 0);
        chk("err", err, m_err);
    endtask

    task automatic drain();
        int n, k;
        for (n = 0; n < 60 && q.size() > 0; n++) begin
            clr();
            k = 0;
            foreach (q[i]) if (!q[i].done && k < 3) begin
                cmp(k, q[i].rn);
                k++;
            end
            step();
        end
        chk("drain_occ", occ, 0);
    endtask

    initial begin
        int rsel;
        logic [3:0] r0;
        errors = 0;
        checks = 0;
        m_tail = 0;
        m_err = 0;
        clr();
        reset = 1;
        step();
        step();
        reset = 0;
        step();
        chk("reset_empty", empty, 1);

        // Pair dispatch, out-of-order completion, paired retire.
        dA(0, 32'h100, 33, 5, 1, 0);
        dB(1, 32'h104, 34, 6, 1, 0);
        step();
        chk("t1_occ2", occ, 2);
        clr(); cmp(0, 1); step();
        clr(); step();
        chk("t1_noret", ra_v, 0);
        clr(); cmp(1, 0); step();
        clr(); step();
        chk("t1_a_pc", ra_pc, 32'h100);
        chk("t1_a_free", ra_fr, 5);
        chk("t1_b_pc", rb_pc, 32'h104);
        chk("t1_b_free", rb_fr, 6);
        chk("t1_occ0", occ, 0);

        // Younger done first: nothing retires until the head is done.
        dA(2, 32'h108, 35, 7, 1, 0);
        dB(3, 32'h10c, 36, 8, 1, 0);
        step();
        clr(); cmp(2, 3); step();
        clr(); step(); step();
        chk("t2_inorder", ra_v, 0);
        cmp(0, 2); step();
        clr(); step();
        chk("t2_both", {ra_v, rb_v}, 2'b11);

        // Capacity: 15 then overflow pair then a single.
        for (int i = 0; i < 7; i++) begin
            dA(4'(m_tail), 32'h1000 + i, 10, 11, 1, 0);
            dB(4'(m_tail + 1), 32'h2000 + i, 12, 13, 1, 0);
            step();
        end
        clr(); dA(4'(m_tail), 32'h3000, 14, 15, 1, 0); step();
        chk("t3_occ15", occ, 15);
        chk("t3_full", full, 1);
        dA(4'(m_tail), 32'h3004, 1, 2, 1, 0);
        dB(4'(m_tail + 1), 32'h3008, 3, 4, 1, 0);
        step();
        chk("t3_err", err, 1);
        chk("t3_drop", occ, 15);
        clr(); dA(4'(m_tail), 32'h300c, 1, 2, 1, 0); step();
        chk("t3_occ16", occ, 16);
        drain();

        // Walk head/tail to 14, then wrap a pair across 15 -> 0.
        for (int i = 0; i < 5; i++) begin
            clr();
            dA(4'(m_tail), 32'h400, 1, 1, 1, 0);
            dB(4'(m_tail + 1), 32'h404, 2, 2, 1, 0);
            step();
        end
        drain();
        seen.delete();
        clr(); dA(14, 32'h338, 20, 21, 1, 0); dB(15, 32'h33c, 22, 23, 1, 0);
        step();
        clr(); dA(0, 32'h300, 24, 25, 1, 0); dB(1, 32'h304, 26, 27, 1, 0);
        step();
        clr(); cmp(0, 14); cmp(1, 15); cmp(2, 0); step();
        clr(); cmp(0, 1); step();
        clr(); step(); step(); step();
        chk("t4_cnt", seen.size(), 4);
        if (seen.size() == 4) begin
            chk("t4_r0", seen[0], 32'h338);
            chk("t4_r1", seen[1], 32'h33c);
            chk("t4_r2", seen[2], 32'h300);
            chk("t4_r3", seen[3], 32'h304);
        end
        chk("t4_occ0", occ, 0);

        // Store retirement.
        r0 = 4'(m_tail);
        clr(); dA(r0, 32'h500, 0, 0, 0, 1); step();
        clr(); cmp(2, r0); step();
        clr(); step();
        chk("t5_store", ra_st, 1);
        chk("t5_nofree", ra_fv, 0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            clr();
            if ($urandom % 4 != 0) begin
                rsel = $urandom % 3;
                if ((16 - q.size() >= (rsel == 2 ? 2 : 1)) ||
                    ($urandom % 20 == 0)) begin
                    if (rsel != 1)
                        dA(4'(m_tail), $urandom, 6'($urandom),
                           ($urandom % 4 == 0) ? 6'd0 : 6'($urandom),
                           1'($urandom), 1'($urandom));
                    if (rsel != 0)
                        dB(rsel == 2 ? 4'(m_tail + 1) : 4'(m_tail),
                           $urandom, 6'($urandom),
                           ($urandom % 4 == 0) ? 6'd0 : 6'($urandom),
                           1'($urandom), 1'($urandom));
                    if ($urandom % 30 == 0) a_rn = a_rn ^ 4'd1;
                end
            end
            for (int k = 0; k < 3; k++) begin
                if ($urandom % 25 == 0)
                    cmp(k, 4'($urandom));
                else if ($urandom % 3 != 0 && q.size() > 0)
                    cmp(k, q[$urandom_range(0, q.size() - 1)].rn);
            end
            step();
        end

        // Reset with six entries in flight, two of them done.
        clr(); reset = 1; step(); reset = 0;
        for (int i = 0; i < 3; i++) begin
            clr();
            dA(4'(2 * i), 32'h600 + 8 * i, 7, 8, 1, 0);
            dB(4'(2 * i + 1), 32'h604 + 8 * i, 9, 10, 1, 0);
            step();
        end
        clr(); cmp(0, 0); cmp(1, 1); step();
        chk("t7_occ6", occ, 6);
        clr(); reset = 1; step(); reset = 0;
        chk("t7_noret", ra_v, 0);
        chk("t7_occ0", occ, 0);
        chk("t7_empty", empty, 1);
        clr(); step();
        chk("t7_noret2", {ra_v, rb_v}, 2'b00);
        dA(0, 32'h700, 3, 4, 1, 0); step();
        chk("t7_accept", occ, 1);
        chk("t7_noerr", err, 0);
        clr(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
